adder: RTL and testbench
========================

ADDER -- requirements
Module: adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 10, giving the operand width in bits (legal range 1..64).
REQ-002 The block SHALL have port clk, input, 1 bit, rising-edge clock.
REQ-003 The block SHALL have port reset, input, 1 bit, reset, asynchronous, active-low.
REQ-004 The block SHALL have port a, input, WIDTH bits, unsigned addend A.
REQ-005 The block SHALL have port b, input, WIDTH bits, unsigned addend B.
REQ-006 The block SHALL have port c, output, WIDTH+1 bits, registered unsigned sum a+b.

Function
REQ-007 The block SHALL treat a and b as unsigned and compute the full-precision sum a+b, with the carry-out in c[WIDTH].
REQ-008 The block SHALL never overflow, truncate or saturate c; the maximum value is 2*(2^WIDTH-1).
REQ-009 The block SHALL have a latency of exactly one clock: c after rising edge k equals a+b sampled at edge k.
REQ-010 The block SHALL register c only; it SHALL have no combinational path from a or b to c.
REQ-011 The block SHALL accept new operands on every clock, giving a throughput of one sum per cycle with no stall or handshake (base build).
REQ-012 The block SHALL leave c unaffected by changes to a or b between clock edges.
REQ-013 The block SHALL, on the first rising edge after reset deasserts, load a+b from the inputs on that edge.

Reset
REQ-014 The block SHALL force c to 0 immediately while reset is low, independent of clk.
REQ-015 The block SHALL hold c at 0 for as long as reset stays low, even if a and b toggle.
REQ-016 The block SHALL discard any operand sampled before reset, including when reset asserts mid-stream.
REQ-017 The block SHALL synchronise reset deassertion to clk outside the block; internally, reset SHALL act only as an asynchronous clear.

Configuration
REQ-018 Macro ADDER_VALID_EN, when defined, SHALL add input in_valid (1 bit) and output out_valid (1 bit, registered, reset 0).
REQ-019 With ADDER_VALID_EN defined, c SHALL update only on edges where in_valid=1 and hold otherwise; out_valid SHALL equal in_valid delayed by one clock.
REQ-020 Without ADDER_VALID_EN, neither port SHALL exist and c SHALL update every clock.

Structure
REQ-021 Shared package adder_pkg SHALL hold the constant ADDER_DEFAULT_WIDTH = 10 and the function adder_sum_width(w) = w+1.
REQ-022 The design SHALL include one combinational sub-module, adder_ripple (parameter WIDTH; ports a, b, sum of WIDTH+1 bits), built as a generate-loop ripple-carry chain of full-adder bit slices with carry-in 0.
REQ-023 The adder top level SHALL contain only adder_ripple, the output register and, when ADDER_VALID_EN is defined, the valid logic.

Verification (WIDTH=10)
REQ-024 Reset: hold reset low, drive a=5 and b=7 -> c=0 on every clock; release reset -> c=12 after the next rising edge.
REQ-025 Maximum carry: a=1023, b=1023 -> c=2046 one clock later; a=512, b=512 -> c=1024 (carry bit set, low bits 0).
REQ-026 Streaming latency: change a and b every clock at the falling edge (for example 1+2, then 3+4, then 100+200) -> c=3, 7, 300 on consecutive clocks, each one cycle after its operands.
REQ-027 Mid-stream reset: while streaming a=10, b=20, pull reset low between edges -> c=0 immediately, without waiting for a clock edge.
REQ-028 Random check: 1000 random operand pairs, each compared one clock later against the model a+b -> zero mismatches.
REQ-029 ADDER_VALID_EN build: in_valid=0 with a=9, b=9 -> c holds its prior value and out_valid=0; in_valid=1 -> c=18 and out_valid=1 one clock later.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared constants and helpers for the registered adder.
// Optional valid tracking is enabled with ADDER_VALID_EN.
package adder_pkg;

  localparam int ADDER_DEFAULT_WIDTH = 10;

  function automatic int adder_sum_width(input int w);
    return w + 1;
  endfunction

endpackage

// File: rtl/adder_ripple.sv
// Combinational ripple-carry adder built from full-adder bit slices.
// Carry-in is tied to zero; sum[WIDTH] is the carry-out.
module adder_ripple
  import adder_pkg::*;
#(
  parameter int WIDTH = ADDER_DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH:0]   sum
);

  logic [WIDTH:0] carry;

  assign carry[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_slice
    logic p;
    assign p          = a[i] ^ b[i];
    assign sum[i]     = p ^ carry[i];
    assign carry[i+1] = (a[i] & b[i]) | (p & carry[i]);
  end

  assign sum[WIDTH] = carry[WIDTH];

endmodule

// File: rtl/adder.sv
// Registered full-precision unsigned adder, one sum per clock.
// Define ADDER_VALID_EN to add in_valid/out_valid qualification.
module adder
  import adder_pkg::*;
#(
  parameter int WIDTH = ADDER_DEFAULT_WIDTH
) (
  input  logic                              clk,
  input  logic                              reset,
`ifdef ADDER_VALID_EN
  input  logic                              in_valid,
  output logic                              out_valid,
`endif
  input  logic [WIDTH-1:0]                  a,
  input  logic [WIDTH-1:0]                  b,
  output logic [adder_sum_width(WIDTH)-1:0] c
);

  localparam int SW = adder_sum_width(WIDTH);

  logic [SW-1:0] sum;
  logic [SW-1:0] c_d;
  logic [SW-1:0] c_q;

  adder_ripple #(
    .WIDTH (WIDTH)
  ) u_ripple (
    .a   (a),
    .b   (b),
    .sum (sum)
  );

`ifdef ADDER_VALID_EN
  logic valid_q;

  always_comb begin
    c_d = c_q;
    if (in_valid) c_d = sum;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) valid_q <= 1'b0;
    else        valid_q <= in_valid;
  end

  assign out_valid = valid_q;
`else
  always_comb c_d = sum;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) c_q <= '0;
    else        c_q <= c_d;
  end

  assign c = c_q;

endmodule

// File: tb/tb_adder.sv
// Directed and random checks for the registered adder.
// Exercises the valid path when ADDER_VALID_EN is defined.
module tb_adder;

  localparam int W = 10;

  logic         clk;
  logic         reset;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W:0]   c;
  logic         in_valid;
  logic         out_valid;

  int n_cmp;
  int n_err;

  adder #(
    .WIDTH (W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
`ifdef ADDER_VALID_EN
    .in_valid  (in_valid),
    .out_valid (out_valid),
`endif
    .a         (a),
    .b         (b),
    .c         (c)
  );

`ifndef ADDER_VALID_EN
  assign out_valid = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    reset = 1'b1;
    a = 10'd5;
    b = 10'd7;
    #1 reset = 1'b0;
    #1;
    n_cmp++;
    if (c !== 11'd0) begin
      n_err++;
      $display("FAIL reset_async: c=%0d want 0", c);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (c !== 11'd0) begin
        n_err++;
        $display("FAIL reset_hold%0d: c=%0d want 0", i, c);
      end
      a = a + 10'd3;
      b = b + 10'd1;
    end
    a = 10'd5;
    b = 10'd7;
    reset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (c !== 11'd12) begin
      n_err++;
      $display("FAIL reset_release: c=%0d want 12", c);
    end
  endtask

  task automatic test_max_carry();
    a = 10'd1023;
    b = 10'd1023;
    @(negedge clk);
    n_cmp++;
    if (c !== 11'd2046) begin
      n_err++;
      $display("FAIL max_sum: c=%0d want 2046", c);
    end
    a = 10'd512;
    b = 10'd512;
    @(negedge clk);
    n_cmp++;
    if (c !== 11'd1024) begin
      n_err++;
      $display("FAIL carry_only: c=%0d want 1024", c);
    end
    a = 10'd1023;
    b = 10'd1;
    @(negedge clk);
    n_cmp++;
    if (c !== 11'd1024) begin
      n_err++;
      $display("FAIL carry_ripple: c=%0d want 1024", c);
    end
  endtask

  task automatic test_streaming();
    a = 10'd1;
    b = 10'd2;
    @(negedge clk);
    n_cmp++;
    if (c !== 11'd3) begin
      n_err++;
      $display("FAIL stream0: c=%0d want 3", c);
    end
    a = 10'd3;
    b = 10'd4;
    @(negedge clk);
    n_cmp++;
    if (c !== 11'd7) begin
      n_err++;
      $display("FAIL stream1: c=%0d want 7", c);
    end
    a = 10'd100;
    b = 10'd200;
    @(negedge clk);
    n_cmp++;
    if (c !== 11'd300) begin
      n_err++;
      $display("FAIL stream2: c=%0d want 300", c);
    end
  endtask

  task automatic test_hold_between_edges();
    a = 10'd40;
    b = 10'd2;
    @(negedge clk);
    a = 10'd900;
    b = 10'd77;
    #2;
    n_cmp++;
    if (c !== 11'd42) begin
      n_err++;
      $display("FAIL hold_between: c=%0d want 42", c);
    end
  endtask

  task automatic test_midstream_reset();
    a = 10'd10;
    b = 10'd20;
    @(negedge clk);
    n_cmp++;
    if (c !== 11'd30) begin
      n_err++;
      $display("FAIL mid_pre: c=%0d want 30", c);
    end
    #2 reset = 1'b0;
    #1;
    n_cmp++;
    if (c !== 11'd0) begin
      n_err++;
      $display("FAIL mid_async: c=%0d want 0", c);
    end
    a = 10'd600;
    b = 10'd300;
    @(negedge clk);
    n_cmp++;
    if (c !== 11'd0) begin
      n_err++;
      $display("FAIL mid_hold: c=%0d want 0", c);
    end
    a = 10'd11;
    b = 10'd22;
    reset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (c !== 11'd33) begin
      n_err++;
      $display("FAIL mid_release: c=%0d want 33", c);
    end
  endtask

  task automatic test_random();
    logic [W:0] exp;
    for (int i = 0; i < 1000; i++) begin
      a = W'($urandom);
      b = W'($urandom);
      exp = {1'b0, a} + {1'b0, b};
      @(negedge clk);
      n_cmp++;
      if (c !== exp) begin
        n_err++;
        $display("FAIL rand%0d: c=%0d want %0d", i, c, exp);
      end
    end
  endtask

`ifdef ADDER_VALID_EN
  task automatic test_valid();
    a = 10'd50;
    b = 10'd5;
    in_valid = 1'b1;
    @(negedge clk);
    a = 10'd9;
    b = 10'd9;
    in_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (c !== 11'd55 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL valid_hold: c=%0d ov=%0b want 55/0", c, out_valid);
    end
    in_valid = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (c !== 11'd18 || out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL valid_load: c=%0d ov=%0b want 18/1", c, out_valid);
    end
  endtask
`endif

  initial begin
    n_cmp = 0;
    n_err = 0;
    in_valid = 1'b1;
    test_reset();
    test_max_carry();
    test_streaming();
    test_hold_between_edges();
    test_midstream_reset();
`ifdef ADDER_VALID_EN
    test_valid();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
